// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch squash, memory wait states, timeout.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int  MAX_WAIT = 255,
    localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_WREG,
    input  logic        ex_M2REG,
    input  logic [4:0]  ex_nd,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_ce,
    output logic        ifid_ce,
    output logic        idex_ce,
    output logic        exmem_ce,
    output logic        memwb_ce,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_err,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             dstall;
    logic             lu;

    assign dstall = mem_req & ~mem_ready;
    assign lu     = ex_M2REG & ex_WREG & (ex_nd != 5'd0) &
                    ((id_uses_rs & (id_rs == ex_nd)) | (id_uses_rt & (id_rt == ex_nd)));

    // Priority: error > data stall > load-use > branch redirect > fetch stall > normal.
    always_comb begin
        pc_ce       = 1'b1;
        ifid_ce     = 1'b1;
        idex_ce     = 1'b1;
        exmem_ce    = 1'b1;
        memwb_ce    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (state_q == ERR) begin
            pc_ce       = 1'b0;
            ifid_ce     = 1'b0;
            idex_ce     = 1'b0;
            exmem_ce    = 1'b0;
            memwb_ce    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (dstall) begin
            pc_ce       = 1'b0;
            ifid_ce     = 1'b0;
            idex_ce     = 1'b0;
            exmem_ce    = 1'b0;
            memwb_flush = 1'b1;
        end else if (lu) begin
            pc_ce      = 1'b0;
            ifid_ce    = 1'b0;
            idex_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_ce      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (dstall) begin
                    state_d    = DWAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            DWAIT: begin
                if (!dstall) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Counters freeze once the controller has locked up in ERR.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ERR) begin
            if (!pc_ce) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (ifid_flush || idex_flush) begin
                flush_cnt_d = flush_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (MAX_WAIT=4): directed scenarios plus randomized traffic
// against a behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

    localparam int MAXW = 4;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_nd;
    logic        id_uses_rs, id_uses_rt, ex_WREG, ex_M2REG;
    logic        branch_taken, imem_ready, mem_req, mem_ready;
    logic        pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        mem_err;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;
    logic [8:0]  ctrl;

    int          vectors = 0;
    int          miscompares = 0;
    bit          perfEn;

    int          consec;
    bit          mErr;
    logic [31:0] mStall, mFlush;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_WREG(ex_WREG), .ex_M2REG(ex_M2REG), .ex_nd(ex_nd),
        .branch_taken(branch_taken), .imem_ready(imem_ready),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_ce(pc_ce), .ifid_ce(ifid_ce), .idex_ce(idex_ce), .exmem_ce(exmem_ce), .memwb_ce(memwb_ce),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .mem_err(mem_err), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl = {pc_ce, ifid_ce, idex_ce, exmem_ce, memwb_ce, ifid_flush, idex_flush, exmem_flush, memwb_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected enables/clears, bit order {pc,ifid,idex,exmem,memwb CE, ifid,idex,exmem,memwb flush}.
    function automatic logic [8:0] expCtrl();
        bit ds;
        bit hit;
        ds  = mem_req && !mem_ready;
        hit = ex_M2REG && ex_WREG && (ex_nd != 0) &&
              ((id_uses_rs && id_rs == ex_nd) || (id_uses_rt && id_rt == ex_nd));
        if (mErr)          return 9'b00000_1111;
        if (ds)            return 9'b00001_0001;
        if (hit)           return 9'b00111_0100;
        if (branch_taken)  return 9'b11111_1000;
        if (!imem_ready)   return 9'b01111_1000;
        return 9'b11111_0000;
    endfunction

    function automatic logic [1:0] expState();
        if (mErr) return 2'd2;
        return (consec > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic modelReset();
        consec = 0;
        mErr   = 1'b0;
        mStall = '0;
        mFlush = '0;
    endtask

    // Advances the model by one clock using the inputs that were held through the edge.
    task automatic modelStep();
        logic [8:0] e;
        e = expCtrl();
        if (!mErr) begin
            if (!e[8]) mStall = mStall + 32'd1;
            if (e[3] || e[2]) mFlush = mFlush + 32'd1;
            if (mem_req && !mem_ready) begin
                if (consec == MAXW) mErr = 1'b1;
                else consec = consec + 1;
            end else begin
                consec = 0;
            end
        end
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        compare("ctrl", {23'd0, ctrl}, {23'd0, expCtrl()});
        compare("state", {30'd0, state}, {30'd0, expState()});
        compare("mem_err", {31'd0, mem_err}, {31'd0, mErr});
        compare("stall_cnt", stall_cnt, perfEn ? mStall : 32'd0);
        compare("flush_cnt", flush_cnt, perfEn ? mFlush : 32'd0);
    endtask

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic wreg, input logic m2reg,
                                 input logic [4:0] nd, input logic br, input logic imem,
                                 input logic mreq, input logic mrdy);
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        ex_WREG      = wreg;
        ex_M2REG     = m2reg;
        ex_nd        = nd;
        branch_taken = br;
        imem_ready   = imem;
        mem_req      = mreq;
        mem_ready    = mrdy;
    endtask

    task automatic setIdle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic evalCycle();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic endCycle();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idleCycle();
        setIdle();
        evalCycle();
        endCycle();
    endtask

    // Asserts reset mid-cycle and checks the asynchronous clear before any clock edge.
    task automatic doReset();
        setIdle();
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        compare("rst_state", {30'd0, state}, 32'd0);
        compare("rst_mem_err", {31'd0, mem_err}, 32'd0);
        compare("rst_ctrl", {23'd0, ctrl}, {23'd0, 9'b11111_0000});
        compare("rst_stall_cnt", stall_cnt, 32'd0);
        compare("rst_flush_cnt", flush_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic loadUse();
        applyStimulus(5'd8, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
`ifdef PIPE_PERF_CNT_EN
        perfEn = 1'b1;
`else
        perfEn = 1'b0;
`endif
        rst = 1'b0;
        modelReset();
        setIdle();
        doReset();

        // Two load-use bubbles and one taken branch.
        loadUse();
        evalCycle();
        compare("lu_ctrl", {23'd0, ctrl}, {23'd0, 9'b00111_0100});
        endCycle();
        idleCycle();
        compare("lu_release_ctrl", {23'd0, ctrl}, {23'd0, 9'b11111_0000});
        loadUse();
        evalCycle();
        endCycle();
        idleCycle();
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        evalCycle();
        endCycle();
        idleCycle();
        compare("perf_stall_cnt", stall_cnt, perfEn ? 32'd2 : 32'd0);
        compare("perf_flush_cnt", flush_cnt, perfEn ? 32'd3 : 32'd0);

        // A load into r0 never interlocks.
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        evalCycle();
        compare("r0_ctrl", {23'd0, ctrl}, {23'd0, 9'b11111_0000});
        endCycle();

        // Redirect wins over a fetch wait.
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        evalCycle();
        compare("br_imem_ctrl", {23'd0, ctrl}, {23'd0, 9'b11111_1000});
        endCycle();

        // Three data wait cycles, then completion.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            evalCycle();
            compare("dwait_state", {30'd0, state}, (i == 0) ? 32'd0 : 32'd1);
            compare("dwait_ctrl", {23'd0, ctrl}, {23'd0, 9'b00001_0001});
            endCycle();
        end
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        evalCycle();
        compare("dwait_done_state", {30'd0, state}, 32'd1);
        compare("dwait_done_ctrl", {23'd0, ctrl}, {23'd0, 9'b11111_0000});
        endCycle();
        idleCycle();
        compare("dwait_back_state", {30'd0, state}, 32'd0);

        // Reset in the middle of a wait clears the wait count.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            evalCycle();
            endCycle();
        end
        compare("pre_reset_state", {30'd0, state}, 32'd1);
        doReset();

        // Timeout: five consecutive wait cycles lock the controller.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
            evalCycle();
            compare("timeout_not_err", {30'd0, state}, (i == 0) ? 32'd0 : 32'd1);
            endCycle();
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom));
            evalCycle();
            compare("err_state", {30'd0, state}, 32'd2);
            compare("err_mem_err", {31'd0, mem_err}, 32'd1);
            compare("err_ctrl", {23'd0, ctrl}, {23'd0, 9'b00000_1111});
            endCycle();
        end
        doReset();

        // Randomized traffic with small register numbers so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            int rdyPct;
            rdyPct = (i < 750) ? 65 : 20;
            if ((mErr && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                doReset();
            end
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                          1'($urandom), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) < rdyPct));
            evalCycle();
            endCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
